// File: rtl/opcode_assembler.sv
// Packs three 32-bit bus words into a 96-bit opcode and queues it in a small FIFO.
// Optional shape range check on assembly: define OPASM_SHAPE_CHECK_EN.
module opcode_assembler #(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [3:0] MAX_SHAPE  = 4'd5
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [31:0]                     word_in,
  input  logic                            word_valid,
  output logic                            word_ready,
  input  logic                            flush,
  output logic [95:0]                     opcode_out,
  output logic                            opcode_valid,
  input  logic                            opcode_ready,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
  output logic                            busy,
  output logic                            shape_err
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    W0 = 2'd0,
    W1 = 2'd1,
    W2 = 2'd2
  } phase_e;

  phase_e        phase;
  logic [63:0]   hold;
  logic [95:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          acc;
  logic          last;
  logic          bad;
  logic          push;
  logic          pop;

  assign full  = (count == CW'(FIFO_DEPTH));
  assign empty = (count == '0);

  // A stalled W2 word waits for a registered free slot, never for this cycle's pop.
  assign word_ready   = !rst && !(phase == W2 && full);
  assign opcode_valid = !rst && !empty;
  assign busy         = !rst && ((phase != W0) || !empty);
  assign opcode_out   = mem[rp];
  assign fifo_count   = count;

  assign acc  = word_valid && word_ready && !flush;
  assign last = acc && (phase == W2);
  assign push = last && !bad;
  assign pop  = opcode_valid && opcode_ready && !flush;

`ifdef OPASM_SHAPE_CHECK_EN
  assign bad = (hold[63:60] > MAX_SHAPE);
`else
  logic unused_max_shape;
  assign unused_max_shape = ^MAX_SHAPE;
  assign bad = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      phase     <= W0;
      wp        <= '0;
      rp        <= '0;
      count     <= '0;
      shape_err <= 1'b0;
    end else if (flush) begin
      phase     <= W0;
      wp        <= '0;
      rp        <= '0;
      count     <= '0;
      shape_err <= 1'b0;
    end else begin
      shape_err <= last && bad;
      if (acc) begin
        unique case (phase)
          W0:      phase <= W1;
          W1:      phase <= W2;
          default: phase <= W0;
        endcase
      end
      if (push) wp <= wp + PW'(1);
      if (pop)  rp <= rp + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Holding register keeps its contents between opcodes.
  always_ff @(posedge clk) begin
    if (acc && phase == W0) hold[63:32] <= word_in;
    if (acc && phase == W1) hold[31:0]  <= word_in;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= {hold, word_in};
  end

endmodule

// File: tb/tb_opcode_assembler.sv
// Randomized bench for opcode_assembler against a queue-based reference model.
module tb_opcode_assembler;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] word_in;
  logic        word_valid;
  logic        word_ready;
  logic        flush;
  logic [95:0] opcode_out;
  logic        opcode_valid;
  logic        opcode_ready;
  logic [2:0]  fifo_count;
  logic        busy;
  logic        shape_err;

  int tests = 0;
  int fails = 0;

  opcode_assembler #(.FIFO_DEPTH(DEPTH), .MAX_SHAPE(4'd5)) dut (
    .clk          (clk),
    .rst          (rst),
    .word_in      (word_in),
    .word_valid   (word_valid),
    .word_ready   (word_ready),
    .flush        (flush),
    .opcode_out   (opcode_out),
    .opcode_valid (opcode_valid),
    .opcode_ready (opcode_ready),
    .fifo_count   (fifo_count),
    .busy         (busy),
    .shape_err    (shape_err)
  );

  always #5 clk = ~clk;

`ifdef OPASM_SHAPE_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  // Reference model: words collected so far and the opcode queue.
  logic [31:0] m_words [$];
  logic [95:0] m_q [$];
  bit          m_serr;

  task automatic check(input string tag, input logic [95:0] got,
                       input logic [95:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit m_ready();
    return !(m_words.size() == 2 && m_q.size() == DEPTH);
  endfunction

  task automatic compare_all();
    check("word_ready", 96'(word_ready), 96'(!rst && m_ready()));
    check("opcode_valid", 96'(opcode_valid), 96'(!rst && m_q.size() != 0));
    check("fifo_count", 96'(fifo_count), 96'(m_q.size()));
    check("busy", 96'(busy),
          96'(!rst && (m_words.size() != 0 || m_q.size() != 0)));
    check("shape_err", 96'(shape_err), 96'(m_serr));
    if (!rst && m_q.size() != 0) check("opcode_out", opcode_out, m_q[0]);
  endtask

  task automatic model_edge();
    logic [95:0] op;
    bit rdy;
    bit do_pop;
    rdy = m_ready();
    if (rst || flush) begin
      m_words.delete();
      m_q.delete();
      m_serr = 1'b0;
      return;
    end
    do_pop = (m_q.size() != 0) && opcode_ready;
    m_serr = 1'b0;
    if (do_pop) void'(m_q.pop_front());
    if (word_valid && rdy) begin
      m_words.push_back(word_in);
      if (m_words.size() == 3) begin
        op = {m_words[0], m_words[1], m_words[2]};
        m_words.delete();
        if (CHK && op[95:92] > 4'd5) m_serr = 1'b1;
        else m_q.push_back(op);
      end
    end
  endtask

  task automatic step(input bit wv, input logic [31:0] wd, input bit ordy,
                      input bit fl);
    word_valid   = wv;
    word_in      = wd;
    opcode_ready = ordy;
    flush        = fl;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  function automatic logic [31:0] legal_word();
    logic [31:0] w;
    w = $urandom;
    w[31:28] = 4'($urandom_range(0, 5));
    return w;
  endfunction

  initial begin
    rst = 1'b1;
    word_valid = 1'b0;
    word_in = '0;
    opcode_ready = 1'b0;
    flush = 1'b0;
    m_serr = 1'b0;
    repeat (2) @(posedge clk);
    model_edge();
    #1;
    compare_all();
    rst = 1'b0;
    step(0, 0, 0, 0);

    // Documented single opcode, popped as soon as it appears.
    step(1, 32'h1ABC_DEF0, 1, 0);
    step(1, 32'h1111_2222, 1, 0);
    step(1, 32'h3333_4444, 1, 0);
    check("example_op", opcode_out, 96'h1ABCDEF0_11112222_33334444);
    step(0, 0, 1, 0);
    check("example_drained", 96'(fifo_count), 96'd0);

    // Fill, stall the fifth W2, then release with a same-cycle pop.
    for (int i = 0; i < 14; i++) step(1, legal_word(), 0, 0);
    check("full_count", 96'(fifo_count), 96'd4);
    check("w2_stall", 96'(word_ready), 96'd0);
    step(1, 32'h2222_0005, 1, 0);
    check("pop_no_push", 96'(fifo_count), 96'd3);
    step(1, 32'h2222_0005, 0, 0);
    check("late_push", 96'(fifo_count), 96'd4);
    for (int i = 0; i < 6; i++) step(0, 0, 1, 0);

    // Flush mid-opcode with a word offered in the same cycle.
    step(1, 32'h0AAA_0001, 0, 0);
    step(1, 32'h0AAA_0002, 0, 0);
    step(1, 32'h0AAA_0003, 0, 1);
    check("flush_idle", 96'(busy), 96'd0);
    step(1, 32'h0BBB_0001, 0, 0);
    step(1, 32'h0BBB_0002, 0, 0);
    step(1, 32'h0BBB_0003, 0, 0);
    check("post_flush_op", opcode_out, 96'h0BBB0001_0BBB0002_0BBB0003);
    step(0, 0, 1, 0);

    // Out-of-range shape code.
    step(1, 32'h7000_0000, 0, 0);
    step(1, 32'h0, 0, 0);
    step(1, 32'h0, 0, 0);
    check("shape_err_pulse", 96'(shape_err), 96'(CHK));
    check("shape_count", 96'(fifo_count), 96'(!CHK));
    step(0, 0, 1, 0);
    check("shape_err_clear", 96'(shape_err), 96'd0);

    // Random traffic with varying consumer pressure.
    for (int seg = 0; seg < 30; seg++) begin
      int rdy_pct;
      rdy_pct = $urandom_range(0, 100);
      for (int c = 0; c < 100; c++) begin
        rst = ($urandom_range(0, 299) == 0);
        step($urandom_range(0, 99) < 75,
             ($urandom_range(0, 3) == 0) ? 32'($urandom) : legal_word(),
             $urandom_range(0, 99) < rdy_pct,
             $urandom_range(0, 59) == 0);
      end
      rst = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
